// File: rtl/audio_min_max_stream.sv
// Streaming per-channel max/min/peak-to-peak over windows of channel-interleaved signed samples.
// Supports single-shot (hold in DONE) and continuous (back-to-back) windowing.
module audio_min_max_stream #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned MAX_LEN = 4096,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         cont,
  input  logic [LEN_W-1:0]             win_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         d,
  output logic [NUM_CH*DATA_W-1:0]     out_max,
  output logic [NUM_CH*DATA_W-1:0]     out_min,
  output logic [NUM_CH*(DATA_W+1)-1:0] out_p2p
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                     state_q, state_d;
  logic                       d_q, d_d;
  logic                       cont_q;
  logic [LEN_W-1:0]           len_q, len_eff, frame_q;
  logic [CH_W-1:0]            ch_q;
  logic [NUM_CH-1:0]          seen_q, seen_upd;
  logic signed [DATA_W-1:0]   max_q [NUM_CH];
  logic signed [DATA_W-1:0]   min_q [NUM_CH];
  logic signed [DATA_W-1:0]   max_upd [NUM_CH];
  logic signed [DATA_W-1:0]   min_upd [NUM_CH];
  logic signed [DATA_W-1:0]   sample;
  logic [NUM_CH*(DATA_W+1)-1:0] p2p_upd;
  logic                       accept, last, complete;

  assign sample   = in_data;
  assign in_ready = (state_q == StRun);
  assign d        = d_q;
  assign accept   = in_valid & in_ready;
  assign last     = accept && (frame_q == len_q - LEN_W'(1)) && (ch_q == CH_W'(NUM_CH - 1));
  // A start on the completing edge wins: the window is dropped, no d.
  assign complete = last & ~start;

  always_comb begin
    len_eff = win_len;
    if (win_len == '0) begin
      len_eff = LEN_W'(1);
    end else if (win_len > LEN_W'(MAX_LEN)) begin
      len_eff = LEN_W'(MAX_LEN);
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    if (start) begin
      state_d = StRun;
      d_d     = 1'b0;
    end else if (complete) begin
      state_d = cont_q ? StRun : StDone;
      d_d     = 1'b1;
    end else if (state_q == StRun) begin
      d_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      d_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
    end
  end

  // Accumulators with the current accepted sample folded in; feeds both state and results.
  always_comb begin
    seen_upd = seen_q;
    p2p_upd  = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      max_upd[c] = max_q[c];
      min_upd[c] = min_q[c];
      if (accept && (ch_q == CH_W'(c))) begin
        seen_upd[c] = 1'b1;
        if (!seen_q[c] || (sample > max_q[c])) max_upd[c] = sample;
        if (!seen_q[c] || (sample < min_q[c])) min_upd[c] = sample;
      end
      p2p_upd[c*(DATA_W+1) +: DATA_W+1] = {max_upd[c][DATA_W-1], max_upd[c]} -
                                          {min_upd[c][DATA_W-1], min_upd[c]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cont_q  <= 1'b0;
      len_q   <= '0;
      frame_q <= '0;
      ch_q    <= '0;
      seen_q  <= '0;
      out_max <= '0;
      out_min <= '0;
      out_p2p <= '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        max_q[c] <= '0;
        min_q[c] <= '0;
      end
    end else if (start) begin
      len_q   <= len_eff;
      cont_q  <= cont;
      frame_q <= '0;
      ch_q    <= '0;
      seen_q  <= '0;
    end else if (accept) begin
      if (complete) begin
        frame_q <= '0;
        ch_q    <= '0;
        seen_q  <= '0;
        out_p2p <= p2p_upd;
        for (int c = 0; c < int'(NUM_CH); c++) begin
          out_max[c*DATA_W +: DATA_W] <= max_upd[c];
          out_min[c*DATA_W +: DATA_W] <= min_upd[c];
        end
      end else begin
        seen_q <= seen_upd;
        max_q  <= max_upd;
        min_q  <= min_upd;
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          ch_q    <= '0;
          frame_q <= frame_q + LEN_W'(1);
        end else begin
          ch_q    <= ch_q + CH_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_min_max_stream.sv
// Scoreboard bench: dut1 is 1-channel 32-bit (MAX_LEN 4), dut2 is 2-channel 8-bit.
// Expected windows are queued by the stimulus; monitors pop on each rising edge of d.
module tb_audio_min_max_stream;

  typedef struct packed {logic [31:0] mx; logic [31:0] mn; logic [32:0] p;} exp1_t;
  typedef struct packed {logic [15:0] mx; logic [15:0] mn; logic [17:0] p;} exp2_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic        start1, cont1, valid1, ready1, d1;
  logic [2:0]  len1;
  logic [31:0] data1, max1, min1;
  logic [32:0] p2p1;

  logic        start2, cont2, valid2, ready2, d2;
  logic [4:0]  len2;
  logic [7:0]  data2;
  logic [15:0] max2, min2;
  logic [17:0] p2p2;

  exp1_t q1[$];
  exp2_t q2[$];
  exp1_t m1;
  exp2_t m2;
  logic  d1_prev = 1'b0;
  logic  d2_prev = 1'b0;
  int    w;

  always #5 clk = ~clk;

  audio_min_max_stream #(.DATA_W(32), .NUM_CH(1), .MAX_LEN(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .cont(cont1), .win_len(len1),
    .in_valid(valid1), .in_ready(ready1), .in_data(data1), .d(d1),
    .out_max(max1), .out_min(min1), .out_p2p(p2p1)
  );

  audio_min_max_stream #(.DATA_W(8), .NUM_CH(2), .MAX_LEN(16)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .cont(cont2), .win_len(len2),
    .in_valid(valid2), .in_ready(ready2), .in_data(data2), .d(d2),
    .out_max(max2), .out_min(min2), .out_p2p(p2p2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitors: every rising edge of d must match the oldest queued window.
  always @(negedge clk) begin
    if (d1 && !d1_prev) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected d: got d=1, want no completion");
      end else begin
        m1 = q1.pop_front();
        check("dut1 max", max1, m1.mx);
        check("dut1 min", min1, m1.mn);
        check("dut1 p2p", p2p1, m1.p);
      end
    end
    d1_prev = d1;
  end

  always @(negedge clk) begin
    if (d2 && !d2_prev) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut2 unexpected d: got d=1, want no completion");
      end else begin
        m2 = q2.pop_front();
        check("dut2 max", max2, m2.mx);
        check("dut2 min", min2, m2.mn);
        check("dut2 p2p", p2p2, m2.p);
      end
    end
    d2_prev = d2;
  end

  task automatic push1(input logic [31:0] mx, input logic [31:0] mn, input logic [32:0] p);
    exp1_t e;
    e.mx = mx; e.mn = mn; e.p = p;
    q1.push_back(e);
  endtask

  task automatic push2(input logic [15:0] mx, input logic [15:0] mn, input logic [17:0] p);
    exp2_t e;
    e.mx = mx; e.mn = mn; e.p = p;
    q2.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_1(input int len, input logic c);
    start1 = 1'b1; len1 = len[2:0]; cont1 = c;
    cyc(1);
    start1 = 1'b0;
  endtask

  task automatic start_2(input int len, input logic c);
    start2 = 1'b1; len2 = len[4:0]; cont2 = c;
    cyc(1);
    start2 = 1'b0;
  endtask

  // Presents a sample and returns once it has been accepted; waits = stall cycles seen.
  task automatic send1(input logic [31:0] v, output int waits);
    logic ok;
    valid1 = 1'b1; data1 = v; waits = 0; ok = 1'b0;
    while (!ok && waits < 20) begin
      @(negedge clk);
      ok = ready1;
      cyc(1);
      if (!ok) waits++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL dut1 accept timeout: got no in_ready, want accept");
    end
  endtask

  task automatic send2(input logic [7:0] v);
    logic ok;
    int   waits;
    valid2 = 1'b1; data2 = v; waits = 0; ok = 1'b0;
    while (!ok && waits < 20) begin
      @(negedge clk);
      ok = ready2;
      cyc(1);
      if (!ok) waits++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL dut2 accept timeout: got no in_ready, want accept");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    {start1, cont1, valid1, len1, data1} = '0;
    {start2, cont2, valid2, len2, data2} = '0;
    #12;
    check("reset ready", {63'd0, ready1}, 64'd0);
    check("reset d", {63'd0, d1}, 64'd0);
    check("reset max", max1, 64'd0);
    check("reset p2p", p2p1, 64'd0);
    reset = 1'b1;
    cyc(1);

    // Single window, one channel.
    start_1(4, 1'b0);
    send1(32'd196608, w);
    send1(32'hFFFF0000, w);
    send1(32'd458752, w);
    push1(32'd458752, 32'hFFFF0000, 33'd524288);
    send1(32'd0, w);
    valid1 = 1'b0;
    cyc(3);
    check("done d held", {63'd0, d1}, 64'd1);
    check("done ready low", {63'd0, ready1}, 64'd0);

    // Continuous windows of two frames, back-to-back.
    start_1(2, 1'b1);
    send1(32'd1, w);
    check("cont no stall 1", w, 64'd0);
    push1(32'd2, 32'd1, 33'd1);
    send1(32'd2, w);
    check("cont no stall 2", w, 64'd0);
    send1(32'd9, w);
    check("cont no stall 3", w, 64'd0);
    push1(32'd9, 32'hFFFFFFFC, 33'd13);
    send1(32'hFFFFFFFC, w);
    check("cont no stall 4", w, 64'd0);
    valid1 = 1'b0;
    cyc(2);
    check("cont d pulse", {63'd0, d1}, 64'd0);
    check("cont ready", {63'd0, ready1}, 64'd1);
    check("cont max held", max1, 64'd9);

    // Abort, then start coincident with the last accept; win_len 0 gives one frame.
    start_1(2, 1'b0);
    send1(32'd5, w);
    start1 = 1'b1; len1 = 3'd0; cont1 = 1'b0; valid1 = 1'b1; data1 = 32'd7;
    cyc(1);
    start1 = 1'b0; valid1 = 1'b0;
    cyc(1);
    check("coinc no d", {63'd0, d1}, 64'd0);
    check("coinc max", max1, 64'd9);
    check("coinc min", min1, 64'hFFFFFFFC);
    check("coinc p2p", p2p1, 64'd13);
    push1(32'hFFFFFFEC, 32'hFFFFFFEC, 33'd0);
    send1(32'hFFFFFFEC, w);
    valid1 = 1'b0;
    cyc(1);
    check("len0 done", {63'd0, d1}, 64'd1);

    // win_len above MAX_LEN clamps to 4 frames.
    start_1(7, 1'b0);
    send1(32'd3, w);
    send1(32'd1, w);
    send1(32'd4, w);
    check("clamp not early", {63'd0, d1}, 64'd0);
    push1(32'd4, 32'd1, 33'd3);
    send1(32'd1, w);
    valid1 = 1'b0;

    // dut2: samples offered while idle are ignored.
    valid2 = 1'b1; data2 = 8'd100;
    cyc(2);
    check("idle ready low", {63'd0, ready2}, 64'd0);
    valid2 = 1'b0;

    // Two channels with valid gaps.
    start_2(2, 1'b0);
    send2(8'd5);
    send2(8'hFD);
    valid2 = 1'b0;
    cyc(1);
    send2(8'hF9);
    valid2 = 1'b0;
    cyc(2);
    push2(16'hFD05, 16'hFDF9, {9'd0, 9'd12});
    send2(8'hFD);
    valid2 = 1'b0;
    cyc(2);
    check("dut2 done d", {63'd0, d2}, 64'd1);

    // Full-scale extremes: p2p needs the extra bit.
    start_2(2, 1'b0);
    check("start clears d", {63'd0, d2}, 64'd0);
    send2(8'h7F);
    send2(8'h80);
    send2(8'h80);
    push2(16'h7F7F, 16'h8080, {9'd255, 9'd255});
    send2(8'h7F);
    valid2 = 1'b0;
    cyc(2);

    // Asynchronous reset mid-window.
    start_2(3, 1'b1);
    send2(8'd1);
    valid2 = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("async ready", {63'd0, ready2}, 64'd0);
    check("async d", {63'd0, d2}, 64'd0);
    check("async max", max2, 64'd0);
    check("async min", min2, 64'd0);
    check("async p2p", p2p2, 64'd0);
    check("async dut1 max", max1, 64'd0);
    check("async dut1 d", {63'd0, d1}, 64'd0);
    cyc(2);
    reset = 1'b1;
    cyc(2);

    check("dut1 pending windows", q1.size(), 64'd0);
    check("dut2 pending windows", q2.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
